// File: rtl/fifo_tx_serializer_if.sv
// Read-side bundle between the byte FIFO and the serializer, plus the serial line status.
// master = serializer side, slave = FIFO/line side.
interface fifo_tx_serializer_if #(
  parameter int width = 8
) ();
  logic             enable;
  logic             empty;
  logic [width-1:0] fifo_data;
  logic             rd;
  logic             tx;
  logic             busy;
  logic             tx_done;

  modport master (
    input  enable,
    input  empty,
    input  fifo_data,
    output rd,
    output tx,
    output busy,
    output tx_done
  );

  modport slave (
    output enable,
    output empty,
    output fifo_data,
    input  rd,
    input  tx,
    input  busy,
    input  tx_done
  );
endinterface

// File: rtl/fifo_tx_serializer.sv
// Pops bytes from the FIFO read port and sends each as a start/data(LSB first)/stop frame on tx.
// Optional even-parity bit between data and stop when FIFO_TX_PARITY_EN is defined.
module fifo_tx_serializer #(
  parameter int width        = 8,
  parameter int clks_per_bit = 4
) (
  input  logic                 rd_clk,
  input  logic                 reset_n,
  fifo_tx_serializer_if.master bus
);

  localparam int cnt_width = $clog2(clks_per_bit + 1);
  localparam int idx_width = (width > 1) ? $clog2(width) : 1;
  localparam logic [cnt_width-1:0] cnt_last = cnt_width'(clks_per_bit - 1);
  localparam logic [idx_width-1:0] idx_last = idx_width'(width - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_START,
    ST_DATA,
`ifdef FIFO_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [idx_width-1:0] idx_q, idx_d;
  logic [width-1:0]     shift_q, shift_d;
  logic                 rd_q, rd_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 bit_end;
`ifdef FIFO_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == cnt_last);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef FIFO_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: if (bus.enable && !bus.empty) state_d = ST_POP;
      ST_POP:  state_d = ST_LOAD;
      ST_LOAD: begin
        // fifo_data is valid now, one cycle after the rd strobe.
        shift_d = bus.fifo_data;
        cnt_d   = '0;
        idx_d   = '0;
`ifdef FIFO_TX_PARITY_EN
        parity_d = ^bus.fifo_data;
`endif
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + cnt_width'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == idx_last) begin
            idx_d = '0;
`ifdef FIFO_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + idx_width'(1);
          end
        end else begin
          cnt_d = cnt_q + cnt_width'(1);
        end
      end
`ifdef FIFO_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + cnt_width'(1);
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + cnt_width'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered without extra latency.
    rd_d      = (state_d == ST_POP);
    busy_d    = (state_d != ST_IDLE);
    tx_done_d = (state_d == ST_STOP) && (cnt_d == cnt_last);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge rd_clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      // NOTE: the shift register is reset as well; it is small and keeps tx free of X after reset.
      shift_q   <= '0;
      rd_q      <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rd_q      <= rd_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
`ifdef FIFO_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign bus.rd      = rd_q;
  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = tx_done_q;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed bench for fifo_tx_serializer: FIFO stand-in, frame-timeline reference model
// checked every cycle, plus literal waveform checks. Honours FIFO_TX_PARITY_EN.
module tb_fifo_tx_serializer;

  localparam int W = 8;
`ifdef FIFO_TX_PARITY_EN
  localparam int CPB = 1;
  localparam int PAR = 1;
`else
  localparam int CPB = 4;
  localparam int PAR = 0;
`endif
  // POP + LOAD + start/data/[parity]/stop bits
  localparam int FLEN = 2 + (W + 2 + PAR) * CPB;
  localparam int TMAX = 4096;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  fifo_tx_serializer_if #(.width(W)) bus ();

  fifo_tx_serializer #(.width(W), .clks_per_bit(CPB)) dut (
    .rd_clk  (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [W-1:0] fq[$];   // FIFO contents seen by the DUT
  logic [W-1:0] mq[$];   // the model's own copy of what should be sent
  logic         rd_last = 1'b0;

  // Model: t = cycles since the POP cycle of the current frame, -1 when idle.
  int           t   = -1;
  logic [W-1:0] cur = '0;

  logic tr_tx   [TMAX];
  logic tr_rd   [TMAX];
  logic tr_done [TMAX];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_tx(input int tt, input logic [W-1:0] d);
    int b;
    if (tt < 2) return 1'b1;
    b = (tt - 2) / CPB;
    if (b == 0) return 1'b0;
    if (b <= W) return d[b-1];
    if (PAR != 0 && b == W + 1) return ^d;
    return 1'b1;
  endfunction

  task automatic model_advance(input logic rst_s, input logic en_s, input logic em_s);
    if (!rst_s) begin
      t = -1;
    end else if (t < 0) begin
      if (en_s && !em_s) begin
        t = 0;
        if (mq.size() > 0) cur = mq.pop_front();
        else cur = 'x;
      end
    end else begin
      t++;
      if (t >= FLEN) t = -1;
    end
  endtask

  task automatic step();
    logic en_s, em_s, rst_s;
    @(posedge clk);
    en_s  = bus.enable;
    em_s  = bus.empty;
    rst_s = reset_n;
    model_advance(rst_s, en_s, em_s);
    #1;
    // FIFO read port: data for a rd strobe appears the following cycle
    if (rd_last && fq.size() > 0) bus.fifo_data = fq.pop_front();
    bus.empty = (fq.size() == 0);
    cyc++;
    if (cyc < TMAX) begin
      tr_tx[cyc]   = bus.tx;
      tr_rd[cyc]   = bus.rd;
      tr_done[cyc] = bus.tx_done;
    end
    check("rd",      bus.rd,      t == 0);
    check("busy",    bus.busy,    t >= 0);
    check("tx",      bus.tx,      (t < 0) ? 1'b1 : exp_tx(t, cur));
    check("tx_done", bus.tx_done, t == FLEN - 1);
    rd_last = bus.rd;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [W-1:0] d);
    fq.push_back(d);
    mq.push_back(d);
    bus.empty = 1'b0;
  endtask

  task automatic wait_rd(input int budget, output int r);
    r = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.rd === 1'b1) begin
        r = cyc;
        break;
      end
    end
    if (r < 0) check("wait_rd timeout", 0, 1);
  endtask

  function automatic logic tx_at(input int i);
    if (i < 0 || i >= TMAX || i > cyc) return 1'bx;
    return tr_tx[i];
  endfunction

  function automatic int count_rd(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (i >= 0 && i < TMAX && tr_rd[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_done(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (i >= 0 && i < TMAX && tr_done[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_tx0(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (i >= 0 && i < TMAX && tr_tx[i] !== 1'b1) n++;
    return n;
  endfunction

  function automatic int first_done(input int a);
    for (int i = a; i <= cyc && i < TMAX; i++) if (i >= 0 && tr_done[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int first_tx0(input int a);
    for (int i = a; i <= cyc && i < TMAX; i++) if (i >= 0 && tr_tx[i] === 1'b0) return i;
    return -1;
  endfunction

  initial begin
    int r, r2, s, d;
    logic [9:0]  a5_frame;
    logic [39:0] obs40, exp40;
    logic [8:0]  b4_head, obs9;

    bus.enable    = 1'b1;
    bus.empty     = 1'b1;
    bus.fifo_data = '0;
    reset_n       = 1'b0;

    // Reset held 3 cycles with data available and enable high
    push(8'h3C);
    run(3);
    check("rd during reset", count_rd(1, 3), 0);
    check("tx low during reset", count_tx0(1, 3), 0);
    reset_n = 1'b1;
    wait_rd(5, r);
    check("first rd cycle after reset", r, 4);
    run(FLEN + 4);
    check("tx high in LOAD", tx_at(r + 1), 1'b1);
    check("tx low 2 cycles after rd", tx_at(r + 2), 1'b0);

    // Single byte 8'hA5
    push(8'hA5);
    wait_rd(5, r);
    run(FLEN + 4);
    check("A5 rd pulses", count_rd(r, cyc), 1);
    check("A5 tx_done pulses", count_done(r, cyc), 1);
`ifndef FIFO_TX_PARITY_EN
    a5_frame = 10'b1101001010;
    for (int j = 0; j < 40; j++) begin
      obs40[j] = tx_at(r + 2 + j);
      exp40[j] = a5_frame[j / 4];
    end
    check("A5 waveform", obs40, exp40);
    check("A5 tx_done in frame cycle 40", first_done(r), r + 41);
`else
    check("A5 parity bit", tx_at(r + 2 + 9), 1'b0);
    check("A5 11-cycle frame", first_done(r), r + 12);
    push(8'h07);
    wait_rd(5, r);
    run(FLEN + 4);
    check("07 parity bit", tx_at(r + 2 + 9), 1'b1);
    check("07 11-cycle frame", first_done(r), r + 12);
`endif

    // Back-to-back frames
    push(8'h01);
    push(8'hFF);
    wait_rd(5, r);
    run(2 * FLEN + 8);
    check("back-to-back rd pulses", count_rd(r, cyc), 2);
    d = first_done(r);
    check("stop-to-start gap", first_tx0(d + 1) - d, 4);

    // Empty FIFO with enable high
    s = cyc;
    run(100);
    check("empty: no rd", count_rd(s + 1, cyc), 0);
    check("empty: tx idle", count_tx0(s + 1, cyc), 0);

    // Data available but enable low
    bus.enable = 1'b0;
    push(8'h5A);
    push(8'hC3);
    s = cyc;
    run(20);
    check("disabled: no rd", count_rd(s + 1, cyc), 0);

    // Enable dropped while in DATA: frame completes, no further pop
    bus.enable = 1'b1;
    wait_rd(5, r);
    run(2 + 2 * CPB);
    bus.enable = 1'b0;
    run(FLEN + 20);
    check("enable drop: no further rd", count_rd(r + 1, cyc), 0);
    check("enable drop: frame completes", count_done(r, cyc), 1);
    bus.enable = 1'b1;
    wait_rd(5, r);
    run(FLEN + 4);

    // Reset during DATA bit 3
    push(8'h96);
    push(8'h4B);
    wait_rd(5, r);
    run(2 + 4 * CPB);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("tx after mid-frame reset", bus.tx, 1'b1);
    check("busy after mid-frame reset", bus.busy, 1'b0);
    wait_rd(5, r2);
    run(FLEN + 4);
    b4_head = 9'b010010110;
    for (int j = 0; j < 9; j++) obs9[j] = tx_at(r2 + 2 + j * CPB + CPB / 2);
    check("next byte after reset is 4B", obs9, b4_head);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
